// File: rtl/vending_controller.sv
// Transaction FSM of the vending machine: coin collection, price/stock checks,
// product release, unit-by-unit change return and timed error codes.
module vending_controller #(
    parameter int PRICE0     = 3,
    parameter int PRICE1     = 5,
    parameter int PRICE2     = 7,
    parameter int PRICE3     = 10,
    parameter int STOCK_INIT = 4,
    parameter int MAX_CREDIT = 15,
    parameter int ERR_HOLD   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        coin_valid,
    input  logic [1:0]  coin_val,
    input  logic        sel_valid,
    input  logic [1:0]  sel_item,
    input  logic        cancel,
    input  logic        restock,
    output logic [10:0] number,
    output logic [1:0]  redlight,
    output logic        vend_pulse,
    output logic [1:0]  vend_item,
    output logic        change_pulse,
    output logic [10:0] owner_total,
    output logic        busy
);

    localparam int CNT_W = $clog2(ERR_HOLD) + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_VEND    = 3'd2;
    localparam logic [2:0] S_CHANGE  = 3'd3;
    localparam logic [2:0] S_ERR     = 3'd4;

    localparam logic [1:0] ERR_CREDIT  = 2'd1;
    localparam logic [1:0] ERR_SOLDOUT = 2'd2;
    localparam logic [1:0] ERR_COIN    = 2'd3;

    logic [2:0]       r_state;
    logic [4:0]       r_credit;
    logic [3:0][3:0]  r_stock;
    logic [10:0]      r_owner;
    logic [1:0]       r_redlight;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_vend_pulse;
    logic [1:0]       r_vend_item;
    logic             r_change_pulse;
    logic             r_busy;

    logic [2:0]       w_state_nxt;
    logic [4:0]       w_credit_nxt;
    logic [3:0][3:0]  w_stock_nxt;
    logic [10:0]      w_owner_nxt;
    logic [1:0]       w_red_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_vend_nxt;
    logic [1:0]       w_vitem_nxt;
    logic             w_chg_nxt;

    logic [4:0]       w_price;
    logic [4:0]       w_coin_amt;
    logic [4:0]       w_sum;
    logic [11:0]      w_owner_sum;

    always_comb begin
        case (sel_item)
            2'd0:    w_price = 5'(PRICE0);
            2'd1:    w_price = 5'(PRICE1);
            2'd2:    w_price = 5'(PRICE2);
            default: w_price = 5'(PRICE3);
        endcase
        case (coin_val)
            2'b00:   w_coin_amt = 5'd1;
            2'b01:   w_coin_amt = 5'd2;
            2'b10:   w_coin_amt = 5'd5;
            default: w_coin_amt = 5'd0;
        endcase
    end

    // Five bits hold MAX_CREDIT plus the largest coin without wrapping.
    assign w_sum       = r_credit + w_coin_amt;
    assign w_owner_sum = {1'b0, r_owner} + {7'd0, w_price};

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_stock_nxt  = r_stock;
        w_owner_nxt  = r_owner;
        w_red_nxt    = r_redlight;
        w_cnt_nxt    = r_err_cnt;
        w_vend_nxt   = 1'b0;
        w_vitem_nxt  = 2'd0;
        w_chg_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (restock) begin
                    for (int i = 0; i < 4; i++) begin
                        w_stock_nxt[i] = 4'(STOCK_INIT);
                    end
                end
                if (cancel) begin
                    w_state_nxt = S_IDLE;
                end else if (sel_valid) begin
                    w_red_nxt   = ERR_CREDIT;
                    w_cnt_nxt   = CNT_W'(ERR_HOLD - 1);
                    w_state_nxt = S_ERR;
                end else if (coin_valid) begin
                    if (coin_val == 2'b11) begin
                        w_red_nxt   = ERR_COIN;
                        w_cnt_nxt   = CNT_W'(ERR_HOLD - 1);
                        w_state_nxt = S_ERR;
                    end else begin
                        w_credit_nxt = w_coin_amt;
                        w_state_nxt  = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (cancel) begin
                    if (r_credit != 5'd0) begin
                        w_chg_nxt    = 1'b1;
                        w_credit_nxt = r_credit - 5'd1;
                        w_state_nxt  = S_CHANGE;
                    end else begin
                        w_state_nxt  = S_IDLE;
                    end
                end else if (sel_valid) begin
                    if (r_stock[sel_item] == 4'd0) begin
                        w_red_nxt   = ERR_SOLDOUT;
                        w_cnt_nxt   = CNT_W'(ERR_HOLD - 1);
                        w_state_nxt = S_ERR;
                    end else if (r_credit < w_price) begin
                        w_red_nxt   = ERR_CREDIT;
                        w_cnt_nxt   = CNT_W'(ERR_HOLD - 1);
                        w_state_nxt = S_ERR;
                    end else begin
                        // The sale is booked here so the VEND cycle already shows it.
                        w_vend_nxt            = 1'b1;
                        w_vitem_nxt           = sel_item;
                        w_credit_nxt          = r_credit - w_price;
                        w_stock_nxt[sel_item] = r_stock[sel_item] - 4'd1;
                        w_owner_nxt           = w_owner_sum[11] ? 11'd2047 : w_owner_sum[10:0];
                        w_state_nxt           = S_VEND;
                    end
                end else if (coin_valid) begin
                    if (coin_val == 2'b11 || w_sum > 5'(MAX_CREDIT)) begin
                        w_red_nxt   = ERR_COIN;
                        w_cnt_nxt   = CNT_W'(ERR_HOLD - 1);
                        w_state_nxt = S_ERR;
                    end else begin
                        w_credit_nxt = w_sum;
                    end
                end
            end
            S_VEND, S_CHANGE: begin
                if (r_credit != 5'd0) begin
                    w_chg_nxt    = 1'b1;
                    w_credit_nxt = r_credit - 5'd1;
                    w_state_nxt  = S_CHANGE;
                end else begin
                    w_state_nxt  = S_IDLE;
                end
            end
            S_ERR: begin
                if (r_err_cnt == '0) begin
                    w_red_nxt   = 2'd0;
                    w_state_nxt = (r_credit != 5'd0) ? S_COLLECT : S_IDLE;
                end else begin
                    w_cnt_nxt   = r_err_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_red_nxt   = 2'd0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_credit       <= 5'd0;
            r_owner        <= 11'd0;
            r_redlight     <= 2'd0;
            r_err_cnt      <= '0;
            r_vend_pulse   <= 1'b0;
            r_vend_item    <= 2'd0;
            r_change_pulse <= 1'b0;
            r_busy         <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_stock[i] <= 4'(STOCK_INIT);
            end
        end else begin
            r_state        <= w_state_nxt;
            r_credit       <= w_credit_nxt;
            r_stock        <= w_stock_nxt;
            r_owner        <= w_owner_nxt;
            r_redlight     <= w_red_nxt;
            r_err_cnt      <= w_cnt_nxt;
            r_vend_pulse   <= w_vend_nxt;
            r_vend_item    <= w_vitem_nxt;
            r_change_pulse <= w_chg_nxt;
            r_busy         <= (w_state_nxt == S_VEND) || (w_state_nxt == S_CHANGE) ||
                              (w_state_nxt == S_ERR);
        end
    end

    assign number       = {6'd0, r_credit};
    assign redlight     = r_redlight;
    assign vend_pulse   = r_vend_pulse;
    assign vend_item    = r_vend_item;
    assign change_pulse = r_change_pulse;
    assign owner_total  = r_owner;
    assign busy         = r_busy;

endmodule

// File: tb/tb_vending_controller.sv
// Self-checking bench for vending_controller: directed scenarios plus random
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_vending_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        coin_valid;
    logic [1:0]  coin_val;
    logic        sel_valid;
    logic [1:0]  sel_item;
    logic        cancel;
    logic        restock;
    logic [10:0] number;
    logic [1:0]  redlight;
    logic        vend_pulse;
    logic [1:0]  vend_item;
    logic        change_pulse;
    logic [10:0] owner_total;
    logic        busy;

    vending_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_valid   (coin_valid),
        .coin_val     (coin_val),
        .sel_valid    (sel_valid),
        .sel_item     (sel_item),
        .cancel       (cancel),
        .restock      (restock),
        .number       (number),
        .redlight     (redlight),
        .vend_pulse   (vend_pulse),
        .vend_item    (vend_item),
        .change_pulse (change_pulse),
        .owner_total  (owner_total),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: credit, stock and revenue as plain integers; the
    // visible activity is a pending vend, a refund in progress or an error timer.
    int mCredit;
    int mOwner;
    int mStock[4];
    int mErrLeft;
    int mErrCode;
    bit mVend;
    int mVendItem;
    bit mChg;
    int prices[4] = '{3, 5, 7, 10};

    int nVend;
    int nChg;
    int nRedCycles;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic void modelReset();
        mCredit  = 0;
        mOwner   = 0;
        mErrLeft = 0;
        mErrCode = 0;
        mVend    = 1'b0;
        mVendItem = 0;
        mChg     = 1'b0;
        for (int i = 0; i < 4; i++) mStock[i] = 4;
    endfunction

    function automatic int coinUnits(input logic [1:0] code);
        case (code)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 5;
            default: return -1;
        endcase
    endfunction

    function automatic void raiseError(input int code);
        mErrCode = code;
        mErrLeft = 8;
    endfunction

    function automatic void modelStep();
        int v;
        if (!rst_n) begin
            modelReset();
            return;
        end
        if (mVend || mChg) begin
            mVend = 1'b0;
            mChg  = (mCredit > 0);
            if (mChg) mCredit--;
        end else if (mErrLeft > 0) begin
            mErrLeft--;
        end else begin
            if (restock && mCredit == 0) begin
                for (int i = 0; i < 4; i++) mStock[i] = 4;
            end
            if (cancel) begin
                if (mCredit > 0) begin
                    mChg = 1'b1;
                    mCredit--;
                end
            end else if (sel_valid) begin
                if (mCredit == 0) raiseError(1);
                else if (mStock[sel_item] == 0) raiseError(2);
                else if (mCredit < prices[sel_item]) raiseError(1);
                else begin
                    mVend     = 1'b1;
                    mVendItem = sel_item;
                    mCredit  -= prices[sel_item];
                    mStock[sel_item]--;
                    mOwner    = (mOwner + prices[sel_item] > 2047) ? 2047
                                                                   : mOwner + prices[sel_item];
                end
            end else if (coin_valid) begin
                v = coinUnits(coin_val);
                if (v < 0 || mCredit + v > 15) raiseError(3);
                else mCredit += v;
            end
        end
    endfunction

    task automatic compareAll(input string where);
        checkOutput({where, ".number"}, number, mCredit);
        checkOutput({where, ".redlight"}, redlight, (mErrLeft > 0) ? mErrCode : 0);
        checkOutput({where, ".vend_pulse"}, vend_pulse, mVend);
        if (mVend) checkOutput({where, ".vend_item"}, vend_item, mVendItem);
        checkOutput({where, ".change_pulse"}, change_pulse, mChg);
        checkOutput({where, ".owner_total"}, owner_total, mOwner);
        checkOutput({where, ".busy"}, busy, mVend || mChg || (mErrLeft > 0));
    endtask

    task automatic applyStimulus(input logic cv, input logic [1:0] cval, input logic sv,
                                 input logic [1:0] sitem, input logic can, input logic rs,
                                 input string where);
        coin_valid = cv;
        coin_val   = cval;
        sel_valid  = sv;
        sel_item   = sitem;
        cancel     = can;
        restock    = rs;
        @(posedge clk);
        modelStep();
        #1;
        compareAll(where);
        nVend      += int'(vend_pulse);
        nChg       += int'(change_pulse);
        nRedCycles += int'(redlight != 2'd0);
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        cancel     = 1'b0;
        restock    = 1'b0;
    endtask

    task automatic insertCoin(input int units);
        logic [1:0] code;
        code = (units == 1) ? 2'b00 : (units == 2) ? 2'b01 : (units == 5) ? 2'b10 : 2'b11;
        applyStimulus(1'b1, code, 1'b0, 2'd0, 1'b0, 1'b0, "coin");
    endtask

    task automatic selectItem(input logic [1:0] item);
        applyStimulus(1'b0, 2'b00, 1'b1, item, 1'b0, 1'b0, "select");
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, "idle");
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        modelReset();
        compareAll("reset");
        @(negedge clk);
        compareAll("reset_hold");
        rst_n = 1'b1;
        nVend = 0;
        nChg = 0;
        nRedCycles = 0;
    endtask

    function automatic void clearCounts();
        nVend = 0;
        nChg = 0;
        nRedCycles = 0;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        coin_valid = 1'b0;
        coin_val = 2'b00;
        sel_valid = 1'b0;
        sel_item = 2'd0;
        cancel = 1'b0;
        restock = 1'b0;
        modelReset();
        clearCounts();

        // Buy item 1 with credit 10: one vend, five units of change.
        doReset();
        insertCoin(5);
        insertCoin(5);
        checkOutput("s1.credit10", number, 10);
        selectItem(2'd1);
        checkOutput("s1.vend_item", vend_item, 1);
        checkOutput("s1.after_vend", number, 5);
        idleCycles(8);
        checkOutput("s1.vend_count", nVend, 1);
        checkOutput("s1.change_count", nChg, 5);
        checkOutput("s1.owner", owner_total, 5);
        checkOutput("s1.final_credit", number, 0);

        // Insufficient credit: error code 1 held exactly eight cycles.
        insertCoin(1);
        insertCoin(2);
        clearCounts();
        selectItem(2'd3);
        idleCycles(11);
        checkOutput("s2.red_cycles", nRedCycles, 8);
        checkOutput("s2.no_vend", nVend, 0);
        checkOutput("s2.credit_kept", number, 3);
        selectItem(2'd0);
        checkOutput("s2.reselect_vend", vend_pulse, 1);
        idleCycles(2);

        // Sell out item 0, then restock and buy again.
        doReset();
        for (int k = 0; k < 4; k++) begin
            insertCoin(1);
            insertCoin(2);
            selectItem(2'd0);
            idleCycles(1);
        end
        checkOutput("s3.four_vends", nVend, 4);
        insertCoin(1);
        insertCoin(2);
        selectItem(2'd0);
        checkOutput("s3.soldout", redlight, 2);
        idleCycles(8);
        applyStimulus(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0, "cancel");
        idleCycles(4);
        applyStimulus(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1, "restock");
        clearCounts();
        insertCoin(1);
        insertCoin(2);
        selectItem(2'd0);
        checkOutput("s3.after_restock", nVend, 1);
        idleCycles(1);

        // Credit ceiling and invalid coin.
        doReset();
        insertCoin(5);
        insertCoin(5);
        insertCoin(2);
        insertCoin(2);
        checkOutput("s4.credit14", number, 14);
        insertCoin(2);
        checkOutput("s4.overflow", redlight, 3);
        checkOutput("s4.kept14", number, 14);
        idleCycles(8);
        insertCoin(1);
        checkOutput("s4.credit15", number, 15);
        insertCoin(0);
        checkOutput("s4.invalid_coin", redlight, 3);
        idleCycles(8);

        // Cancel beats a simultaneous selection.
        doReset();
        insertCoin(5);
        insertCoin(2);
        clearCounts();
        applyStimulus(1'b0, 2'b00, 1'b1, 2'd0, 1'b1, 1'b0, "cancel_sel");
        idleCycles(9);
        checkOutput("s5.refund", nChg, 7);
        checkOutput("s5.no_vend", nVend, 0);

        // Reset in the third cycle of a refund.
        insertCoin(5);
        insertCoin(2);
        applyStimulus(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0, "cancel");
        idleCycles(2);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        compareAll("midreset");
        clearCounts();
        idleCycles(4);
        checkOutput("s6.no_pulses", nChg, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(1);

        // Revenue saturation.
        doReset();
        for (int k = 0; k < 210; k++) begin
            if (k % 4 == 0) applyStimulus(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1, "restock");
            insertCoin(5);
            insertCoin(5);
            selectItem(2'd3);
            idleCycles(1);
        end
        checkOutput("sat.owner", owner_total, 2047);

        // Random traffic.
        doReset();
        for (int k = 0; k < 1500; k++) begin
            applyStimulus(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 11) == 0), ($urandom_range(0, 19) == 0),
                          "random");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
